// File: rtl/sram_block_mover.sv
// Byte-serial COPY/FILL engine that drives the 64x8 on-chip SRAM port.
// It advances only on clk_valid edges. FIN is the exception: it always returns to IDLE.
module sram_block_mover #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clk_valid,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_data,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic              sram_write_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_CNT = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_PTR = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                op_q, op_d;
    logic                err_q, err_d;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // err is a strict one-cycle pulse, so it is cleared on every edge that does not set it.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        op_d    = op_q;
        err_d   = 1'b0;
        if (state_q == ST_FIN) begin
            state_d = ST_IDLE;
        end else if (clk_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (length > DEPTH) begin
                            err_d = 1'b1;
                        end else if (length == '0) begin
                            state_d = ST_FIN;
                        end else begin
                            src_d = src_addr;
                            dst_d = dst_addr;
                            rem_d = length;
                            op_d  = op;
                            if (op) begin
                                data_d  = fill_data;
                                state_d = ST_WRITE;
                            end else begin
                                state_d = ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    data_d  = sram_data_in;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    dst_d = dst_q + ONE_PTR;
                    if (!op_q) begin
                        src_d = src_q + ONE_PTR;
                    end
                    rem_d = rem_q - ONE_CNT;
                    if (rem_q == ONE_CNT) begin
                        state_d = ST_FIN;
                    end else if (op_q) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sram_write_en = 1'b0;
        sram_addr     = '0;
        sram_data_out = '0;
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_FIN);
        err           = err_q;
        case (state_q)
            ST_READ: begin
                sram_addr = src_q;
            end
            ST_WRITE: begin
                sram_write_en = 1'b1;
                sram_addr     = dst_q;
                sram_data_out = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_block_mover.sv
// Bench for sram_block_mover: the bench models the SRAM and keeps a byte-level reference memory.
// Directed scenarios are followed by randomized COPY/FILL operations with clk_valid stalls.
module tb_sram_block_mover;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       clk_valid;
    logic       start;
    logic       op;
    logic [5:0] src_addr;
    logic [5:0] dst_addr;
    logic [6:0] length;
    logic [7:0] fill_data;
    logic [7:0] sram_data_in;
    logic       sram_write_en;
    logic [5:0] sram_addr;
    logic [7:0] sram_data_out;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];
    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    bit cv_tog = 1'b0;

    sram_block_mover #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk(clk), .arst_n(arst_n), .clk_valid(clk_valid), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
        .sram_data_in(sram_data_in), .sram_write_en(sram_write_en), .sram_addr(sram_addr),
        .sram_data_out(sram_data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign sram_data_in = mem[sram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. The SRAM write and done are captured at the negedge before the edge, while they are stable.
    task automatic step();
        logic       wr;
        logic [5:0] a;
        logic [7:0] d;
        wr = clk_valid && sram_write_en;
        a  = sram_addr;
        d  = sram_data_out;
        if (done) done_cnt++;
        @(posedge clk);
        @(negedge clk);
        if (wr) begin
            mem[a] = d;
            wr_cnt++;
        end
    endtask

    function automatic logic next_cv(input int mode);
        if (mode == 1) begin
            cv_tog = ~cv_tog;
            return cv_tog;
        end
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic ref_apply(input bit o, input logic [5:0] s, input logic [5:0] d,
                             input int n, input logic [7:0] f);
        for (int i = 0; i < n; i++) begin
            if (o) ref_mem[(int'(d) + i) % 64] = f;
            else   ref_mem[(int'(d) + i) % 64] = ref_mem[(int'(s) + i) % 64];
        end
    endtask

    task automatic mem_compare(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic preload(input int a, input logic [7:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic do_op(input bit o, input logic [5:0] s, input logic [5:0] d, input int n,
                         input logic [7:0] f, input int mode, input bit busy_start);
        int w0, dc0, vcnt, guard;
        w0  = wr_cnt;
        dc0 = done_cnt;
        op = o; src_addr = s; dst_addr = d; length = 7'(n); fill_data = f;
        start = 1'b1;
        clk_valid = 1'b1;
        step();
        start = 1'b0;
        if (n > 64) begin
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            clk_valid = 1'b1;
            step();
            chk("err_clear", err, 0);
            chk("err_writes", wr_cnt - w0, 0);
            chk("err_no_done", done_cnt - dc0, 0);
            mem_compare("err_mem");
            return;
        end
        vcnt  = 0;
        guard = 0;
        while (!done && guard < 600) begin
            chk("busy_run", busy, 1);
            if (busy_start && guard == 1) begin
                start = 1'b1; op = 1'b1; dst_addr = s; length = 7'd5; fill_data = 8'hEE;
            end else begin
                start = 1'b0;
            end
            clk_valid = next_cv(mode);
            if (clk_valid) vcnt++;
            step();
            guard++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        chk("busy_fin", busy, 1);
        chk("valid_cycles", vcnt, o ? n : 2 * n);
        chk("write_count", wr_cnt - w0, n);
        ref_apply(o, s, d, n, f);
        clk_valid = next_cv(mode);
        step();
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
        chk("done_pulses", done_cnt - dc0, 1);
        mem_compare(o ? "fill_mem" : "copy_mem");
    endtask

    initial begin
        int w0, dc0, guard;
        arst_n = 1'b0; clk_valid = 1'b0; start = 1'b0; op = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
        for (int i = 0; i < 64; i++) preload(i, 8'($urandom));
        step();
        step();
        chk("reset_outputs", {sram_write_en, sram_addr, sram_data_out, busy, done, err}, 0);
        arst_n = 1'b1;
        clk_valid = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Reset mid-FILL after exactly ten writes; the reset edge has clk_valid low so the SRAM sees no write.
        w0 = wr_cnt;
        dc0 = done_cnt;
        op = 1'b1; dst_addr = 6'h00; length = 7'd64; fill_data = 8'h5A; start = 1'b1;
        clk_valid = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (wr_cnt - w0 < 10 && guard < 100) begin
            step();
            guard++;
        end
        chk("midfill_writes", wr_cnt - w0, 10);
        clk_valid = 1'b0;
        arst_n = 1'b0;
        step();
        chk("midreset_outputs", {sram_write_en, sram_addr, sram_data_out, busy, done, err}, 0);
        arst_n = 1'b1;
        step();
        chk("midreset_no_done", done_cnt - dc0, 0);
        ref_apply(1'b1, 6'h00, 6'h00, 10, 8'h5A);
        mem_compare("midreset_mem");

        do_op(1'b1, 6'h00, 6'h3C, 8, 8'hA5, 0, 1'b0);
        chk("wrap_fill_0", mem[0], 8'hA5);
        chk("wrap_fill_63", mem[63], 8'hA5);

        preload(16, 8'd11); preload(17, 8'd22); preload(18, 8'd33); preload(19, 8'd44);
        cv_tog = 1'b0;
        do_op(1'b0, 6'h10, 6'h20, 4, 8'h00, 1, 1'b0);
        chk("stall_copy_23", mem[35], 8'd44);

        preload(0, 8'd1); preload(1, 8'd2); preload(2, 8'd3); preload(3, 8'd4);
        do_op(1'b0, 6'h00, 6'h01, 3, 8'h00, 0, 1'b0);
        chk("smear", {mem[0], mem[1], mem[2], mem[3]}, 32'h01010101);

        do_op(1'b1, 6'h00, 6'h08, 0, 8'hFF, 0, 1'b0);
        do_op(1'b1, 6'h00, 6'h08, 65, 8'hFF, 0, 1'b0);
        do_op(1'b0, 6'h30, 6'h04, 6, 8'h00, 0, 1'b1);

        for (int k = 0; k < 16; k++) begin
            int n;
            if ($urandom_range(0, 9) == 0) n = $urandom_range(65, 127);
            else if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 64);
            else n = $urandom_range(1, 12);
            do_op(1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), n, 8'($urandom),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_block_mover.md
Name: sram_block_mover

Overview:
- Sequential master for the 64x8 on-chip SRAM port. Drives sram_write_en, sram_addr and sram_data_out, and samples sram_data_in.
- Executes two operation types:
  - block COPY: src to dst, one byte at a time, ascending addresses.
  - block FILL: a constant byte written over a range.
- Lets the controller initialise or relocate data memory without per-byte instruction overhead.
- Advances only on clock edges where clk_valid=1, the same qualifier the SRAM uses for writes.

Parameters:
- ADDR_W, 6, SRAM address width (depth = 2**ADDR_W = 64).
- DATA_W, 8, SRAM data width.

Ports:
- clk  input  1  system clock, rising edge.
- arst_n  input  1  active-low reset, synchronous to clk.
- clk_valid  input  1  clock-enable qualifier; state advances only on edges where it is 1.
- start  input  1  operation request; sampled in IDLE only.
- op  input  1  0 = COPY, 1 = FILL; sampled with start.
- src_addr  input  ADDR_W  COPY source start address.
- dst_addr  input  ADDR_W  destination start address.
- length  input  ADDR_W+1  byte count, legal range 0..64.
- fill_data  input  DATA_W  FILL constant.
- sram_data_in  input  DATA_W  SRAM combinational read data for the current sram_addr.
- sram_write_en  output  1  SRAM write strobe.
- sram_addr  output  ADDR_W  SRAM address.
- sram_data_out  output  DATA_W  SRAM write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse: start rejected because length > 64.

Behaviour:
- Reset: arst_n=0 sampled on a rising clk edge, independent of clk_valid.
  - Result: state=IDLE; busy=0, done=0, err=0, sram_write_en=0, sram_addr=0, sram_data_out=0; internal pointers and counter cleared.
  - Reset mid-operation aborts immediately. Bytes already written stay in SRAM; no done pulse.
- State machine: IDLE, READ, WRITE, FIN.
  - Every transition except FIN->IDLE requires clk_valid=1 on that edge.
  - With clk_valid=0, all registers hold.
- IDLE:
  - On start=1 with length>64: err=1 for one cycle, stay IDLE.
  - On start=1 with length=0: go to FIN; no SRAM write.
  - Otherwise: latch the src/dst pointers and remaining=length. For FILL also latch data_q=fill_data.
  - Next state: READ for COPY, WRITE for FILL.
- READ:
  - Drive sram_addr=src_ptr, sram_write_en=0.
  - On the edge: data_q <= sram_data_in, go to WRITE.
- WRITE:
  - Drive sram_addr=dst_ptr, sram_data_out=data_q, sram_write_en=1.
  - On the edge: dst_ptr++, src_ptr++ (COPY only), remaining--.
  - If remaining was 1: go to FIN. Else go to READ (COPY) or stay in WRITE (FILL).
- FIN: done=1 for exactly one clk cycle, then IDLE unconditionally (clk_valid ignored).
- busy=1 in READ, WRITE and FIN; 0 in IDLE.
- start while busy is ignored and not queued.
- Outputs are a decode of registered state and pointers; sram_write_en=0 in every state except WRITE.
- In IDLE and FIN: sram_addr=0, sram_data_out=0.
- Pointer arithmetic is modulo 64: address 63 increments to 0, so ranges wrap silently.
- COPY is strictly forward. When dst is in (src, src+length), source bytes already overwritten are re-read. This smear is the defined behaviour.
- Latency with clk_valid held at 1, start accepted at edge T:
  - COPY N bytes: N writes at edges T+2, T+4 … T+2N.
  - FILL N bytes: writes at edges T+1 … T+N.
  - done is high in the cycle following the last write edge.
- Throughput: COPY 2 valid cycles per byte, FILL 1 valid cycle per byte.

Test Plan:
- Reset mid-FILL: FILL dst=0x00 len=64 fill=0x5A; assert arst_n=0 after 10 writes.
  - Required: bytes 0..9 = 0x5A, bytes 10..63 untouched; all outputs 0 on the next edge; no done pulse.
  - Then FILL dst=0x3C len=8 fill=0xA5.
  - Required: addrs 60..63 and 0..3 = 0xA5 (wrap), done pulse 9 cycles after start, busy high meanwhile.
- COPY with stalls: preload 0x10..0x13 = 11,22,33,44; COPY src=0x10 dst=0x20 len=4; clk_valid toggling 1,0 every cycle.
  - Required: 0x20..0x23 = 11,22,33,44; no write on any edge with clk_valid=0; done pulse after the 4th write.
- Overlapping forward COPY: preload 0x00..0x03 = 1,2,3,4; COPY src=0 dst=1 len=3.
  - Required: memory 0x00..0x03 = 1,1,1,1.
- Zero-length start: start with len=0.
  - Required: busy=1 and done=1 in the next cycle, no sram_write_en.
- Illegal length: start with len=65.
  - Required: err pulse of 1 cycle, busy stays 0, SRAM unchanged.
- Start while busy: a second start during an active COPY is ignored.
  - Required: memory contents match the first operation only; exactly one done pulse.
